// File: rtl/conv33_input_window.sv
// rtl/conv33_input_window.sv - 3x3 sliding window former over a raster pixel stream
module conv33_input_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    output logic [9*DATA_WIDTH-1:0]   out_window,
    output logic                      frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } phase_t;

    phase_t phase;
    phase_t phase_next;

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [DATA_WIDTH-1:0]   lb0 [IMG_W];
    logic [DATA_WIDTH-1:0]   lb1 [IMG_W];
    logic [DATA_WIDTH-1:0]   lb0_rd;
    logic [DATA_WIDTH-1:0]   lb1_rd;
    logic [9*DATA_WIDTH-1:0] win;
    logic [9*DATA_WIDTH-1:0] win_next;
    logic                    col_last;
    logic                    row_last;
    logic                    emit;
    logic                    frame_end;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb0_rd   = lb0[col];
    assign lb1_rd   = lb1[col];

    // Phase register: FILL while the first two rows of a frame load the line buffers
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= FILL;
        end else begin
            phase <= phase_next;
        end
    end

    // Phase transitions and window-emit decision for the pixel being accepted
    always_comb begin
        phase_next = phase;
        emit       = 1'b0;
        frame_end  = 1'b0;
        if (in_valid) begin
            // columns 0 and 1 would mix taps from two different rows
            emit      = (phase == RUN) && (col >= CW'(2));
            frame_end = emit && row_last && col_last;
            if (row_last && col_last) begin
                phase_next = FILL;
            end else if (col_last && (row == RW'(1))) begin
                phase_next = RUN;
            end
        end
    end

    // Next window: every row shifts left, the new column enters at tap column 2
    always_comb begin
        win_next = win;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                win_next[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = win[(3*i+j+1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_next[2*DATA_WIDTH +: DATA_WIDTH] = lb0_rd;
        win_next[5*DATA_WIDTH +: DATA_WIDTH] = lb1_rd;
        win_next[8*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Line buffers carry no reset; rows 0 and 1 of each frame never emit, so stale data is harmless
    always_ff @(posedge clk) begin
        if (rst && in_valid) begin
            lb0[col] <= lb1_rd;
            lb1[col] <= in_data;
        end
    end

    // Raster position counters, window array and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else begin
            out_valid  <= emit;
            frame_done <= frame_end;
            if (in_valid) begin
                win <= win_next;
                if (emit) begin
                    out_window <= win_next;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv33_input_window.sv
// tb/tb_conv33_input_window.sv - scoreboard bench for conv33_input_window (4x4 and 28x28 instances)
module tb_conv33_input_window;

    localparam int SW = 4;
    localparam int SH = 4;
    localparam int LW = 28;
    localparam int LH = 28;

    typedef struct {
        longint      t;
        logic [71:0] w;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv  [2];
    logic [7:0]  id  [2];
    logic        ov  [2];
    logic [71:0] ow  [2];
    logic        fdn [2];

    exp_t        q [2][$];
    logic [7:0]  img [2][LW*LH];
    int          mrow [2];
    int          mcol [2];
    logic [71:0] last_w [2];
    int          win_cnt [2];
    int          fd_cnt [2];
    int          n_pass = 0;
    int          n_chk  = 0;

    always #5 clk = ~clk;

    conv33_input_window #(.DATA_WIDTH(8), .IMG_W(SW), .IMG_H(SH)) dut_s (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_window(ow[0]), .frame_done(fdn[0])
    );

    conv33_input_window #(.DATA_WIDTH(8), .IMG_W(LW), .IMG_H(LH)) dut_l (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_window(ow[1]), .frame_done(fdn[1])
    );

    function automatic int iw(input int i);
        return (i == 0) ? SW : LW;
    endfunction

    function automatic int ih(input int i);
        return (i == 0) ? SH : LH;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Reference model: keep the current frame as an image and cut the 3x3 patch ending at (r,c)
    task automatic drive(input int i, input bit v, input logic [7:0] d);
        exp_t e;
        int   r;
        int   c;
        @(negedge clk);
        iv[i] = v;
        id[i] = d;
        @(posedge clk);
        if (v && rst === 1'b1) begin
            r = mrow[i];
            c = mcol[i];
            img[i][r*iw(i)+c] = d;
            if (r >= 2 && c >= 2) begin
                e.t  = $time + 5;
                e.fd = (r == ih(i) - 1) && (c == iw(i) - 1);
                e.w  = '0;
                for (int a = 0; a < 3; a++)
                    for (int b = 0; b < 3; b++)
                        e.w[(3*a+b)*8 +: 8] = img[i][(r-2+a)*iw(i) + (c-2+b)];
                q[i].push_back(e);
            end
            if (c == iw(i) - 1) begin
                mcol[i] = 0;
                mrow[i] = (r == ih(i) - 1) ? 0 : r + 1;
            end else begin
                mcol[i] = c + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst   = 1'b0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            mrow[i]   = 0;
            mcol[i]   = 0;
            last_w[i] = '0;
            q[i].delete();
        end
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_out_valid[%0d]", i), 72'(ov[i]), 72'd0);
            chk($sformatf("reset_frame_done[%0d]", i), 72'(fdn[i]), 72'd0);
            chk($sformatf("reset_out_window[%0d]", i), ow[i], 72'd0);
        end
        rst = 1'b1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            win_cnt[i] = 0;
            fd_cnt[i]  = 0;
        end
    endtask

    task automatic end_scenario(input string name, input int i, input int wins, input int fds);
        idle(3);
        chk({name, "_windows"}, 72'(win_cnt[i]), 72'(wins));
        chk({name, "_frame_done"}, 72'(fd_cnt[i]), 72'(fds));
        chk({name, "_drained"}, 72'(q[i].size()), 72'd0);
    endtask

    task automatic send_frame(input int i, input int base, input bit gaps);
        for (int p = 0; p < iw(i) * ih(i); p++) begin
            while (gaps && $urandom_range(1, 0) == 1) drive(i, 1'b0, 8'h00);
            drive(i, 1'b1, 8'((base + p) % 256));
        end
    endtask

    // Monitor: pop the scoreboard on every window; between windows outputs must hold
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (ov[i] === 1'b1) begin
                win_cnt[i]++;
                if (fdn[i] === 1'b1) fd_cnt[i]++;
                if (q[i].size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_window[%0d]: got %0h expected none", i, ow[i]);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("latency[%0d]", i), 72'($time), 72'(e.t));
                    chk($sformatf("window[%0d]", i), ow[i], e.w);
                    chk($sformatf("frame_done[%0d]", i), 72'(fdn[i]), 72'(e.fd));
                    last_w[i] = e.w;
                end
            end else begin
                chk($sformatf("idle_out_valid[%0d]", i), 72'(ov[i]), 72'd0);
                chk($sformatf("idle_frame_done[%0d]", i), 72'(fdn[i]), 72'd0);
                chk($sformatf("idle_window_hold[%0d]", i), ow[i], last_w[i]);
                if (q[i].size() > 0 && q[i][0].t <= $time) begin
                    n_chk++;
                    $display("FAIL missing_window[%0d]: got none expected %0h", i, q[i][0].w);
                    void'(q[i].pop_front());
                end
            end
        end
    end

    initial begin
        rst   = 1'b0;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        id[0] = 8'h00;
        id[1] = 8'h00;
        for (int i = 0; i < 2; i++) last_w[i] = '0;
        clear_counts();

        do_reset(3);
        idle(50);
        chk("idle50_windows_s", 72'(win_cnt[0]), 72'd0);
        chk("idle50_windows_l", 72'(win_cnt[1]), 72'd0);

        clear_counts();
        send_frame(0, 0, 1'b0);
        end_scenario("b2b", 0, 4, 1);
        chk("b2b_last_window", ow[0], {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5});

        clear_counts();
        send_frame(0, 0, 1'b1);
        end_scenario("gaps", 0, 4, 1);

        clear_counts();
        send_frame(0, 0, 1'b0);
        send_frame(0, 100, 1'b0);
        end_scenario("two_frames", 0, 8, 2);

        for (int p = 0; p < 9; p++) drive(0, 1'b1, 8'(p + 50));
        do_reset(2);
        clear_counts();
        send_frame(0, 0, 1'b0);
        end_scenario("after_reset", 0, 4, 1);

        clear_counts();
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < SW * SH; p++) begin
                while ($urandom_range(3, 0) == 0) drive(0, 1'b0, 8'h00);
                drive(0, 1'b1, 8'($urandom));
            end
        end
        end_scenario("random_small", 0, 12, 3);

        clear_counts();
        for (int r = 0; r < LH; r++) begin
            for (int c = 0; c < LW; c++) begin
                while ($urandom_range(3, 0) == 0) drive(1, 1'b0, 8'h00);
                drive(1, 1'b1, 8'((r * LW + c) % 256));
            end
        end
        end_scenario("ramp_28", 1, (LW - 2) * (LH - 2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
